// File: rtl/cotm32_pkg.sv
// Core-wide constants shared by the cotm32 datapath blocks.
package cotm32_pkg;
    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
endpackage

// File: rtl/regfile_rport.sv
// One register-file read port: storage mux, write-first bypass, zero/range masking.
// Latency 1 (REG_RDATA=1) or 0 (REG_RDATA=0); no backpressure, a read is accepted every cycle.
module regfile_rport
    import cotm32_pkg::*;
#(
    parameter int N_REGS    = NUM_REGS,
    parameter int N_WPORTS  = 1,
    parameter int REG_RDATA = 1,
    parameter int ZERO_REG  = 1,
    parameter int AW        = $clog2(N_REGS)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ren,
    input  logic [AW-1:0]   i_raddr,
    input  logic [XLEN-1:0] i_regs  [0:N_REGS-1],
    input  logic            i_we    [0:N_WPORTS-1],
    input  logic [AW-1:0]   i_waddr [0:N_WPORTS-1],
    input  logic [XLEN-1:0] i_wdata [0:N_WPORTS-1],
    output logic [XLEN-1:0] o_rdata,
    output logic            o_rvalid
);

    logic            raddr_ok;
    logic [XLEN-1:0] eff_val;

    // A readable address implies any matching write is also not dropped,
    // so the bypass can compare against the raw write enables.
    assign raddr_ok = (int'(i_raddr) < N_REGS) && !((ZERO_REG != 0) && (i_raddr == '0));

    always_comb begin
        eff_val = '0;
        if (raddr_ok) begin
            eff_val = i_regs[i_raddr];
            for (int w = 0; w < N_WPORTS; w++) begin
                if (i_we[w] && (i_waddr[w] == i_raddr)) begin
                    eff_val = i_wdata[w];
                end
            end
        end
    end

    generate
        if (REG_RDATA != 0) begin : g_reg
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    o_rdata  <= '0;
                    o_rvalid <= 1'b0;
                end else begin
                    o_rvalid <= i_ren;
                    if (i_ren) begin
                        o_rdata <= eff_val;
                    end
                end
            end
        end else begin : g_comb
            // Gated by reset so the port reads as idle while the core is held in reset.
            assign o_rvalid = i_ren && i_rst_n;
            assign o_rdata  = o_rvalid ? eff_val : '0;
        end
    endgenerate

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file: storage, write decode with highest-port-wins priority.
// Read latency set by REG_RDATA (1 or 0 cycles); writes land on the next edge; no backpressure.
module register_file_mp
    import cotm32_pkg::*;
#(
    parameter int  N_REGS    = NUM_REGS,
    parameter int  N_RPORTS  = 2,
    parameter int  N_WPORTS  = 1,
    parameter int  REG_RDATA = 1,
    parameter int  ZERO_REG  = 1,
    localparam int AW        = $clog2(N_REGS)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ren    [0:N_RPORTS-1],
    input  logic [AW-1:0]   i_raddr  [0:N_RPORTS-1],
    output logic [XLEN-1:0] o_rdata  [0:N_RPORTS-1],
    output logic            o_rvalid [0:N_RPORTS-1],
    input  logic            i_we     [0:N_WPORTS-1],
    input  logic [AW-1:0]   i_waddr  [0:N_WPORTS-1],
    input  logic [XLEN-1:0] i_wdata  [0:N_WPORTS-1]
);

    logic [XLEN-1:0] regs  [0:N_REGS-1];
    logic [XLEN-1:0] reg_d [0:N_REGS-1];

    // Per-register decode; iterating ports in ascending order lets the highest port win.
    // Addresses beyond N_REGS never match a register index, so those writes fall away.
    always_comb begin
        for (int r = 0; r < N_REGS; r++) begin
            reg_d[r] = regs[r];
            if (!((ZERO_REG != 0) && (r == 0))) begin
                for (int w = 0; w < N_WPORTS; w++) begin
                    if (i_we[w] && (int'(i_waddr[w]) == r)) begin
                        reg_d[r] = i_wdata[w];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < N_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < N_REGS; r++) begin
                regs[r] <= reg_d[r];
            end
        end
    end

    generate
        for (genvar p = 0; p < N_RPORTS; p++) begin : g_rport
            regfile_rport #(
                .N_REGS    (N_REGS),
                .N_WPORTS  (N_WPORTS),
                .REG_RDATA (REG_RDATA),
                .ZERO_REG  (ZERO_REG),
                .AW        (AW)
            ) u_rport (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .i_ren    (i_ren[p]),
                .i_raddr  (i_raddr[p]),
                .i_regs   (regs),
                .i_we     (i_we),
                .i_waddr  (i_waddr),
                .i_wdata  (i_wdata),
                .o_rdata  (o_rdata[p]),
                .o_rvalid (o_rvalid[p])
            );
        end
    endgenerate

endmodule
